// File: rtl/hamming_pkg.sv
// Shared types and Hamming(7,4) helpers for the serial link scheduler.
// Codeword bit i holds c(i+1): {d4, d3, d2, p3, d1, p2, p1}, so c1 is the LSB.
package hamming_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } tx_state_e;

    function automatic logic [6:0] ham_encode(input logic [3:0] d);
        logic p1, p2, p3;
        p1 = d[0] ^ d[1] ^ d[3];
        p2 = d[0] ^ d[2] ^ d[3];
        p3 = d[1] ^ d[2] ^ d[3];
        return {d[3], d[2], d[1], p3, d[0], p2, p1};
    endfunction

    // Result is the 1-based position of the flipped bit, 0 when the word is clean.
    function automatic logic [2:0] ham_syndrome(input logic [6:0] c);
        return {c[3] ^ c[4] ^ c[5] ^ c[6],
                c[1] ^ c[2] ^ c[5] ^ c[6],
                c[0] ^ c[2] ^ c[4] ^ c[6]};
    endfunction

endpackage

// File: rtl/hamming_tag_fifo.sv
// Requester-ID FIFO for codewords in flight between serialiser and deserialiser.
// Pointers carry one extra wrap bit to tell full from empty.
module hamming_tag_fifo #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  logic din,
    input  logic pop,
    output logic dout,
    output logic full,
    output logic empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0] mem;
    logic [AW:0]      wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= din;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/hamming_link_sched.sv
// Two-requester round-robin scheduler onto one serial Hamming(7,4) channel,
// with deserialise/correct on the return path and requester tagging.
module hamming_link_sched
    import hamming_pkg::*;
#(
    parameter int GAP_CYCLES = 1,
    parameter int TAG_DEPTH  = 4,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [3:0]       req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [3:0]       req1_data,
    output logic             req1_ready,
    output logic             tx_serial,
    output logic             tx_frame,
    input  logic             rx_serial,
    input  logic             rx_frame,
    output logic             rx_valid,
    output logic [3:0]       rx_data,
    output logic             rx_id,
    output logic             rx_corrected,
    output logic             rx_orphan,
    output logic [CNT_W-1:0] corr_cnt,
    output logic             busy
);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    tx_state_e     state, state_nxt;
    logic [6:0]    tx_sh;
    logic [2:0]    tx_cnt;
    logic [GW-1:0] gap_cnt;
    logic          last_grant;
    logic          can_grant, hs, hs_id, gap_last;
    logic [3:0]    hs_data;

    logic [5:0]    rx_sh;
    logic [2:0]    rx_cnt;
    logic [6:0]    rx_word;
    logic [2:0]    syn;
    logic          rx_done;
    logic [3:0]    rx_fix;
    logic          tag_full, tag_empty, tag_dout;

    // Ties go to whoever did not win last; a lone requester always wins.
    assign can_grant  = (state == IDLE) && !tag_full;
    assign req0_ready = can_grant && req0_valid && (!req1_valid || last_grant);
    assign req1_ready = can_grant && req1_valid && (!req0_valid || !last_grant);
    assign hs_id      = req1_valid && req1_ready;
    assign hs         = (req0_valid && req0_ready) || hs_id;
    assign hs_data    = hs_id ? req1_data : req0_data;
    assign gap_last   = (int'(gap_cnt) == GAP_CYCLES - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (hs) state_nxt = SEND;
            SEND:    if (tx_cnt == 3'd6) state_nxt = (GAP_CYCLES == 0) ? IDLE : GAP;
            GAP:     if (gap_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        tx_frame  = (state == SEND);
        tx_serial = (state == SEND) && tx_sh[0];
        busy      = (state != IDLE) || !tag_empty;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_sh      <= '0;
            tx_cnt     <= '0;
            gap_cnt    <= '0;
            last_grant <= 1'b1;
        end else begin
            if (hs) begin
                tx_sh      <= ham_encode(hs_data);
                tx_cnt     <= '0;
                last_grant <= hs_id;
            end else if (state == SEND) begin
                tx_sh  <= {1'b0, tx_sh[6:1]};
                tx_cnt <= tx_cnt + 3'd1;
            end
            gap_cnt <= (state == GAP) ? gap_cnt + 1'b1 : '0;
        end
    end

    // rx_word is the frame as it stands including this cycle's bit.
    assign rx_word = {rx_serial, rx_sh};
    assign rx_done = rx_frame && (rx_cnt == 3'd6);
    assign syn     = ham_syndrome(rx_word);
    assign rx_fix  = {rx_word[6], rx_word[5], rx_word[4], rx_word[2]}
                   ^ {syn == 3'd7, syn == 3'd6, syn == 3'd5, syn == 3'd3};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sh  <= '0;
            rx_cnt <= '0;
        end else if (rx_frame) begin
            rx_sh  <= rx_word[6:1];
            rx_cnt <= rx_done ? 3'd0 : rx_cnt + 3'd1;
        end else begin
            rx_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_valid     <= 1'b0;
            rx_orphan    <= 1'b0;
            rx_data      <= '0;
            rx_id        <= 1'b0;
            rx_corrected <= 1'b0;
            corr_cnt     <= '0;
        end else begin
            rx_valid  <= rx_done && !tag_empty;
            rx_orphan <= rx_done && tag_empty;
            if (rx_done && !tag_empty) begin
                rx_data      <= rx_fix;
                rx_id        <= tag_dout;
                rx_corrected <= (syn != 3'd0);
                if ((syn != 3'd0) && (corr_cnt != {CNT_W{1'b1}}))
                    corr_cnt <= corr_cnt + 1'b1;
            end
        end
    end

    hamming_tag_fifo #(
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (hs),
        .din   (hs_id),
        .pop   (rx_done),
        .dout  (tag_dout),
        .full  (tag_full),
        .empty (tag_empty)
    );

endmodule

// File: tb/tb_hamming_link_sched.sv
// Bench for hamming_link_sched: random nibbles and channel bit flips, checked
// against a position-indexed Hamming reference and a handshake/result log.
module tb_hamming_link_sched;
    localparam int GAP_CYCLES = 1;
    localparam int TAG_DEPTH  = 4;
    localparam int CNT_W      = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req0_valid = 1'b0, req1_valid = 1'b0;
    logic [3:0] req0_data = '0, req1_data = '0;
    logic req0_ready, req1_ready, tx_serial, tx_frame, rx_serial, rx_frame;
    logic rx_valid, rx_id, rx_corrected, rx_orphan, busy;
    logic [3:0] rx_data;
    logic [CNT_W-1:0] corr_cnt;

    typedef struct {int cyc; logic id; logic [3:0] data; logic [6:0] flip;} hs_t;
    typedef struct {int cyc; logic [3:0] data; logic id; logic corr;} rx_t;

    hs_t  hs_q[$];
    rx_t  rx_q[$];
    int   tx_cyc_q[$];
    logic tx_bit_q[$];
    int   orphan_n = 0, orphan_cyc = 0;
    int   cyc = 0;
    int   n_chk = 0, n_pass = 0;

    logic       lb_en = 1'b0, man_frame = 1'b0, man_serial = 1'b0;
    logic [6:0] cur_flip = '0, fixed_flip = '0;
    logic [2:0] tx_pos;
    int         flip_mode = 0;
    hs_t        mh;
    rx_t        mr;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign rx_frame  = lb_en ? tx_frame : man_frame;
    assign rx_serial = lb_en ? (tx_serial ^ (tx_frame & cur_flip[tx_pos])) : man_serial;

    always @(posedge clk or negedge rst_n)
        if (!rst_n) tx_pos <= 3'd0;
        else        tx_pos <= tx_frame ? tx_pos + 3'd1 : 3'd0;

    hamming_link_sched #(
        .GAP_CYCLES (GAP_CYCLES), .TAG_DEPTH (TAG_DEPTH), .CNT_W (CNT_W)
    ) dut (
        .clk (clk), .rst_n (rst_n),
        .req0_valid (req0_valid), .req0_data (req0_data), .req0_ready (req0_ready),
        .req1_valid (req1_valid), .req1_data (req1_data), .req1_ready (req1_ready),
        .tx_serial (tx_serial), .tx_frame (tx_frame),
        .rx_serial (rx_serial), .rx_frame (rx_frame),
        .rx_valid (rx_valid), .rx_data (rx_data), .rx_id (rx_id),
        .rx_corrected (rx_corrected), .rx_orphan (rx_orphan),
        .corr_cnt (corr_cnt), .busy (busy)
    );

    // Event recorder; the channel flip for a frame is chosen at its handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
                mh.cyc  = cyc;
                mh.id   = req1_valid && req1_ready;
                mh.data = mh.id ? req1_data : req0_data;
                case (flip_mode)
                    0:       cur_flip = 7'd0;
                    1:       cur_flip = fixed_flip;
                    2:       cur_flip = ($urandom_range(0, 1) == 1) ? 7'(1 << $urandom_range(0, 6)) : 7'd0;
                    default: cur_flip = 7'(1 << $urandom_range(0, 6));
                endcase
                mh.flip = cur_flip;
                hs_q.push_back(mh);
            end
            if (tx_frame) begin
                tx_cyc_q.push_back(cyc);
                tx_bit_q.push_back(tx_serial);
            end
            if (rx_valid) begin
                mr.cyc = cyc; mr.data = rx_data; mr.id = rx_id; mr.corr = rx_corrected;
                rx_q.push_back(mr);
            end
            if (rx_orphan) begin
                orphan_n++;
                orphan_cyc = cyc;
            end
        end
    end

    // Reference codeword: data fills the non-power-of-two positions 3,5,6,7;
    // parity at position 2^k covers every position whose index has bit k set.
    function automatic logic [6:0] model_cw(input logic [3:0] d);
        logic [7:1] c;
        int di;
        c = '0;
        di = 0;
        for (int j = 1; j <= 7; j++)
            if ((j & (j - 1)) != 0) begin c[j] = d[di]; di++; end
        for (int p = 1; p <= 4; p = p * 2)
            for (int j = 3; j <= 7; j++)
                if ((j & p) != 0 && (j & (j - 1)) != 0) c[p] = c[p] ^ c[j];
        return c;
    endfunction

    function automatic logic [6:0] rand_flip();
        return ($urandom_range(0, 1) == 1) ? 7'(1 << $urandom_range(0, 6)) : 7'd0;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        lb_en = 1'b0; man_frame = 1'b0; man_serial = 1'b0; flip_mode = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        hs_q.delete(); rx_q.delete(); tx_cyc_q.delete(); tx_bit_q.delete();
        orphan_n = 0;
    endtask

    // Both requesters stay valid; the granted one gets a fresh nibble.
    task automatic run_reqs(input int want, input int budget, input bit drop);
        int seen;
        seen = hs_q.size();
        @(posedge clk); #1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_data = 4'($urandom); req1_data = 4'($urandom);
        for (int i = 0; i < budget && hs_q.size() < want; i++) begin
            @(posedge clk); #1;
            if (hs_q.size() > seen) begin
                if (hs_q[hs_q.size() - 1].id) req1_data = 4'($urandom);
                else                          req0_data = 4'($urandom);
                seen = hs_q.size();
            end
        end
        if (drop) begin req0_valid = 1'b0; req1_valid = 1'b0; end
    endtask

    task automatic drive_bits(input logic [13:0] b, input int n, output int last);
        last = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            man_frame = 1'b1; man_serial = b[i]; last = cyc;
        end
        @(posedge clk); #1;
        man_frame = 1'b0; man_serial = 1'b0;
    endtask

    task automatic test_reset();
        logic [19:0] outs;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            outs = {req0_ready, req1_ready, tx_serial, tx_frame, rx_valid, rx_data, rx_id,
                    rx_corrected, rx_orphan, corr_cnt, busy};
            n_chk++;
            if (outs !== 20'd0) $display("FAIL reset_idle cyc %0d: outputs %h, want 0", i, outs);
            else n_pass++;
        end
    endtask

    task automatic single_frame(input logic [6:0] flip, input logic exp_corr, input int exp_cnt);
        logic [6:0] bits;
        int T, cbad;
        hs_q.delete(); rx_q.delete(); tx_cyc_q.delete(); tx_bit_q.delete();
        lb_en = 1'b1; flip_mode = 1; fixed_flip = flip;
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_data = 4'b1011;
        for (int i = 0; i < 20 && hs_q.size() == 0; i++) begin @(posedge clk); #1; end
        req0_valid = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        n_chk++;
        if (hs_q.size() != 1 || tx_bit_q.size() != 7 || rx_q.size() != 1) begin
            $display("FAIL single_counts: hs %0d tx %0d rx %0d, want 1 7 1",
                     hs_q.size(), tx_bit_q.size(), rx_q.size());
        end else begin
            n_pass++;
            T = hs_q[0].cyc; bits = '0; cbad = 0;
            for (int k = 0; k < 7; k++) begin
                bits[k] = tx_bit_q[k];
                if (tx_cyc_q[k] != T + 1 + k) cbad++;
            end
            n_chk++;
            if (bits !== 7'b1010101 || cbad != 0)
                $display("FAIL single_tx_bits: bits c7..c1 %b, bad cycles %0d, want 1010101 0", bits, cbad);
            else n_pass++;
            n_chk++;
            if (hs_q[0].id !== 1'b0) $display("FAIL single_grant: id %0d, want 0", hs_q[0].id);
            else n_pass++;
            n_chk++;
            if (rx_q[0].cyc != T + 8 || rx_q[0].data !== 4'b1011 || rx_q[0].id !== 1'b0 ||
                rx_q[0].corr !== exp_corr)
                $display("FAIL single_rx: cyc +%0d data %b id %0d corr %0d, want +8 1011 0 %0d",
                         rx_q[0].cyc - T, rx_q[0].data, rx_q[0].id, rx_q[0].corr, exp_corr);
            else n_pass++;
        end
        n_chk++;
        if (int'(corr_cnt) != exp_cnt) $display("FAIL single_corr_cnt: %0d, want %0d", corr_cnt, exp_cnt);
        else n_pass++;
    endtask

    task automatic test_loopback();
        single_frame(7'd0, 1'b0, 0);
    endtask

    task automatic test_corrected();
        single_frame(7'b0010000, 1'b1, 1);
    endtask

    task automatic test_round_robin();
        logic [3:0] ids;
        logic [6:0] bits;
        int gbad, cbad, nflip;
        do_reset();
        lb_en = 1'b1; flip_mode = 2;
        run_reqs(4, 60, 1'b1);
        repeat (15) @(posedge clk);
        #1;
        n_chk++;
        if (hs_q.size() != 4 || tx_bit_q.size() != 28 || rx_q.size() != 4) begin
            $display("FAIL rr_counts: hs %0d tx %0d rx %0d, want 4 28 4",
                     hs_q.size(), tx_bit_q.size(), rx_q.size());
        end else begin
            n_pass++;
            ids = {hs_q[3].id, hs_q[2].id, hs_q[1].id, hs_q[0].id};
            n_chk++;
            if (ids !== 4'b1010) $display("FAIL rr_ids: ids (last..first) %b, want 1010", ids);
            else n_pass++;
            gbad = 0;
            for (int i = 1; i < 4; i++) if (hs_q[i].cyc - hs_q[i-1].cyc != 8 + GAP_CYCLES) gbad++;
            n_chk++;
            if (gbad != 0) $display("FAIL rr_spacing: %0d gaps off, want 0 (first gap %0d)",
                                    gbad, hs_q[1].cyc - hs_q[0].cyc);
            else n_pass++;
            nflip = 0;
            for (int f = 0; f < 4; f++) begin
                bits = '0; cbad = 0;
                for (int k = 0; k < 7; k++) begin
                    bits[k] = tx_bit_q[f*7 + k];
                    if (tx_cyc_q[f*7 + k] != hs_q[f].cyc + 1 + k) cbad++;
                end
                n_chk++;
                if (bits !== model_cw(hs_q[f].data) || cbad != 0)
                    $display("FAIL rr_tx%0d: bits %b bad cycles %0d, want %b 0",
                             f, bits, cbad, model_cw(hs_q[f].data));
                else n_pass++;
                n_chk++;
                if (rx_q[f].cyc != hs_q[f].cyc + 8 || rx_q[f].data !== hs_q[f].data ||
                    rx_q[f].id !== hs_q[f].id || rx_q[f].corr !== (hs_q[f].flip != 0))
                    $display("FAIL rr_rx%0d: +%0d %h id %0d corr %0d, want +8 %h %0d %0d", f,
                             rx_q[f].cyc - hs_q[f].cyc, rx_q[f].data, rx_q[f].id, rx_q[f].corr,
                             hs_q[f].data, hs_q[f].id, hs_q[f].flip != 0);
                else n_pass++;
                if (hs_q[f].flip != 0) nflip++;
            end
            n_chk++;
            if (int'(corr_cnt) != nflip) $display("FAIL rr_corr_cnt: %0d, want %0d", corr_cnt, nflip);
            else n_pass++;
        end
    endtask

    task automatic test_fifo_full();
        int last;
        do_reset();
        run_reqs(99, 60, 1'b0);
        n_chk++;
        if (hs_q.size() != TAG_DEPTH || req0_ready !== 1'b0 || req1_ready !== 1'b0 || busy !== 1'b1)
            $display("FAIL full_stall: hs %0d ready %b%b busy %b, want %0d 00 1",
                     hs_q.size(), req1_ready, req0_ready, busy, TAG_DEPTH);
        else n_pass++;
        if (hs_q.size() > 0) drive_bits({7'd0, model_cw(hs_q[0].data)}, 7, last);
        repeat (30) @(posedge clk);
        #1;
        n_chk++;
        if (hs_q.size() != TAG_DEPTH + 1 || req0_ready !== 1'b0 || req1_ready !== 1'b0)
            $display("FAIL full_one_more: hs %0d ready %b%b, want %0d 00",
                     hs_q.size(), req1_ready, req0_ready, TAG_DEPTH + 1);
        else n_pass++;
        n_chk++;
        if (rx_q.size() != 1) $display("FAIL full_rx_count: %0d, want 1", rx_q.size());
        else if (rx_q[0].data !== hs_q[0].data || rx_q[0].id !== hs_q[0].id || rx_q[0].corr !== 1'b0)
            $display("FAIL full_rx: %h id %0d corr %0d, want %h %0d 0",
                     rx_q[0].data, rx_q[0].id, rx_q[0].corr, hs_q[0].data, hs_q[0].id);
        else n_pass++;
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [6:0] f0, f1;
        int last, nflip;
        do_reset();
        run_reqs(2, 40, 1'b1);
        f0 = rand_flip(); f1 = rand_flip();
        if (hs_q.size() == 2)
            drive_bits({model_cw(hs_q[1].data) ^ f1, model_cw(hs_q[0].data) ^ f0}, 14, last);
        repeat (10) @(posedge clk);
        #1;
        nflip = int'(f0 != 0) + int'(f1 != 0);
        n_chk++;
        if (rx_q.size() != 2 || hs_q.size() != 2) begin
            $display("FAIL b2b_count: rx %0d hs %0d, want 2 2", rx_q.size(), hs_q.size());
        end else begin
            n_pass++;
            n_chk++;
            if (rx_q[0].data !== hs_q[0].data || rx_q[0].id !== hs_q[0].id || rx_q[0].corr !== (f0 != 0) ||
                rx_q[1].data !== hs_q[1].data || rx_q[1].id !== hs_q[1].id || rx_q[1].corr !== (f1 != 0))
                $display("FAIL b2b_rx: %h/%0d/%0d %h/%0d/%0d, want %h/%0d/%0d %h/%0d/%0d",
                         rx_q[0].data, rx_q[0].id, rx_q[0].corr, rx_q[1].data, rx_q[1].id, rx_q[1].corr,
                         hs_q[0].data, hs_q[0].id, f0 != 0, hs_q[1].data, hs_q[1].id, f1 != 0);
            else n_pass++;
        end
        n_chk++;
        if (int'(corr_cnt) != nflip || orphan_n != 0 || busy !== 1'b0)
            $display("FAIL b2b_state: corr %0d orphans %0d busy %b, want %0d 0 0",
                     corr_cnt, orphan_n, busy, nflip);
        else n_pass++;
    endtask

    task automatic test_partial_orphan();
        int last;
        do_reset();
        drive_bits(14'($urandom), 3, last);
        repeat (3) @(posedge clk);
        #1;
        n_chk++;
        if (rx_q.size() != 0 || orphan_n != 0)
            $display("FAIL partial_discard: rx %0d orphans %0d, want 0 0", rx_q.size(), orphan_n);
        else n_pass++;
        drive_bits({7'd0, model_cw(4'($urandom)) ^ 7'(1 << $urandom_range(0, 6))}, 7, last);
        repeat (4) @(posedge clk);
        #1;
        n_chk++;
        if (orphan_n != 1 || orphan_cyc != last + 1)
            $display("FAIL orphan_pulse: count %0d at +%0d, want 1 at +1", orphan_n, orphan_cyc - last);
        else n_pass++;
        n_chk++;
        if (rx_q.size() != 0 || corr_cnt !== '0)
            $display("FAIL orphan_quiet: rx %0d corr %0d, want 0 0", rx_q.size(), corr_cnt);
        else n_pass++;
    endtask

    task automatic test_saturation();
        int bad;
        do_reset();
        lb_en = 1'b1; flip_mode = 3;
        run_reqs(262, 3500, 1'b1);
        repeat (20) @(posedge clk);
        #1;
        bad = 0;
        if (rx_q.size() == hs_q.size())
            for (int i = 0; i < rx_q.size(); i++)
                if (rx_q[i].data !== hs_q[i].data || rx_q[i].id !== hs_q[i].id || rx_q[i].corr !== 1'b1) bad++;
        n_chk++;
        if (rx_q.size() != 262 || hs_q.size() != 262 || bad != 0)
            $display("FAIL sat_stream: rx %0d hs %0d bad %0d, want 262 262 0", rx_q.size(), hs_q.size(), bad);
        else n_pass++;
        n_chk++;
        if (corr_cnt !== {CNT_W{1'b1}}) $display("FAIL sat_corr_cnt: %0d, want %0d", corr_cnt, (1 << CNT_W) - 1);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        do_reset();
        run_reqs(1, 20, 1'b1);
        repeat (3) @(posedge clk);
        #2;
        n_chk++;
        if (tx_frame !== 1'b1) $display("FAIL areset_pre: tx_frame %b, want 1", tx_frame);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (tx_frame !== 1'b0 || busy !== 1'b0)
            $display("FAIL areset_drop: tx_frame %b busy %b, want 0 0", tx_frame, busy);
        else n_pass++;
        do_reset();
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_corrected();
        test_round_robin();
        test_fifo_full();
        test_back_to_back();
        test_partial_orphan();
        test_saturation();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
